seg7_scan_ctrl: RTL and testbench
=================================

// Module: seg7_scan_ctrl
// PURPOSE
//  Time-multiplexed scan controller for an N-digit common-pin 7-segment display.
//  Owns one shared segment7 decoder and hands it to one digit per refresh slot.
//  Sits between the 0-19 counter's BCD digit outputs and the board's seg/digit pins.
//  Inserts a per-slot blanking gap against ghosting; frame-coherent input snapshot.
// PARAMETERS
//  N_DIGITS      2     digits scanned, 1..8; digit 0 = least significant
//  REFRESH_DIV   1000  clk cycles per digit slot, >= 2
//  BLANK_CYCLES  50    cycles at start of each slot with all digits off, < REFRESH_DIV
// PORTS
//  clk         in   1           system clock, all logic on rising edge
//  rst         in   1           synchronous reset, active-high
//  enable      in   1           1 = scan; 0 = display dark, scan held at start
//  digits_bcd  in   4*N_DIGITS  digit i at [4i+3:4i]
//  seg7        out  7           segment pattern from segment7, registered
//  dig_sel     out  N_DIGITS    digit enables, active-low, registered
//  frame_tick  out  1           1-cycle pulse at end of each full frame
// BEHAVIOUR
//  - Reset (rst=1 at edge): slot_cnt=0, idx=0, snap=0, seg7=7'b0, dig_sel=all 1, frame_tick=0.
//  - rst has priority over enable; rst mid-slot aborts at once, no partial frame kept.
//  - slot_cnt counts 0..REFRESH_DIV-1 while enable=1; at REFRESH_DIV-1 it wraps to 0.
//    On the same edge idx advances, wrapping N_DIGITS-1 -> 0.
//  - Slot phase: SCAN_BLANK while slot_cnt < BLANK_CYCLES, else SCAN_SHOW.
//  - Outputs registered from current (idx, slot_cnt, snap): one-cycle lag.
//    SCAN_BLANK: dig_sel = all 1; seg7 = decode(snap digit idx).
//    SCAN_SHOW:  dig_sel = ~(1<<idx); seg7 = decode(snap digit idx).
//  - Each digit is lit REFRESH_DIV-BLANK_CYCLES cycles per frame.
//    Frame = N_DIGITS*REFRESH_DIV cycles.
//  - snap loads digits_bcd on the edge where idx==N_DIGITS-1 and slot_cnt wraps.
//    frame_tick=1 in the following cycle. Input changes mid-frame are never visible
//    until the next frame.
//  - snap also loads every cycle while enable=0, so the first frame after enable shows
//    current data.
//  - enable=0: next edge slot_cnt=0, idx=0, dig_sel=all 1, frame_tick=0. seg7 keeps decoding.
//    enable 0->1: scan restarts at idx 0, slot_cnt 0, in SCAN_BLANK.
//  - Codes 10..15 are passed to segment7 unmodified; its output is shown as-is.
//  - N_DIGITS=1: idx constant 0, frame_tick every REFRESH_DIV cycles.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//    During SCAN_SHOW, digit i>0 stays dark (dig_sel bit stays 1) when snap digit i and
//    all higher snap digits are 0.
//    Digit 0 is always lit; timing of idx/slot_cnt/frame_tick is unchanged.
//  LEADING_ZERO_BLANK_EN undefined: all digits lit in their slot, zeros shown as "0".
// STRUCTURE
//  - seg7_pkg holds: DIGIT_W=4, SEG_W=7, phase codes SCAN_BLANK/SCAN_SHOW,
//    DIG_ALL_OFF constant.
//  - One sub-module: existing segment7 (num -> seg7), single instance fed by a
//    snap[idx] mux.
//  - Local logic: slot counter, digit index, snapshot register, phase decode,
//    output registers.
// TESTING  (N_DIGITS=2, REFRESH_DIV=8, BLANK_CYCLES=2)
//  1. rst=1 3 cycles, enable=1 -> dig_sel=2'b11, seg7=0, frame_tick=0 throughout reset.
//     dig_sel=2'b10 first appears 3 cycles after release.
//  2. digits_bcd=8'h19 steady -> dig_sel 2'b10 6 cycles with decode(9), 2 dark, then
//     2'b01 6 cycles with decode(1).
//     frame_tick every 16 cycles.
//  3. digits_bcd 8'h19->8'h07 during idx 0 slot -> display stays 1/9 to frame end;
//     0/7 shown only after frame_tick.
//  4. enable=0 mid-SHOW of idx 1 -> next cycle dig_sel=2'b11, no frame_tick.
//     Re-enable -> 2 dark cycles, then digit 0 with current data.
//  5. digits_bcd=8'h05 -> with macro, dig_sel never 2'b01 and digit 0 still shows 5.
//     Without macro, digit 1 shows decode(0). 8'h00 with macro -> digit 0 lit as "0".
//  6. rst pulse 1 cycle during idx 1 SHOW -> next cycle reset values. digits_bcd=8'h0A
//     after -> digit 0 seg7 equals segment7's output for 10.

Source files
------------

// File: rtl/seg7_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seg7_pkg                                                         |
// | Purpose : Shared widths and constants for the 7-segment scan controller.   |
// |           DIGIT_W     - bits per BCD digit                                 |
// |           SEG_W       - bits per segment pattern                           |
// |           SCAN_BLANK / SCAN_SHOW - slot phase codes                        |
// |           DIG_ALL_OFF - active-low digit enables, all digits dark          |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
package seg7_pkg;

   localparam int DIGIT_W    = 4;
   localparam int SEG_W      = 7;
   localparam int MAX_DIGITS = 8;

   // Slot phase: the first part of every slot is dark to suppress ghosting
   localparam logic [0:0] SCAN_BLANK = 1'b0;
   localparam logic [0:0] SCAN_SHOW  = 1'b1;

   // Sized for the widest display; users slice off the digits they need
   localparam logic [MAX_DIGITS-1:0] DIG_ALL_OFF = '1;

endpackage
`default_nettype wire

// File: rtl/seg7_scan_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seg7_scan_ctrl_if                                                |
// | Purpose : Bundles the data/display signals of the scan controller.         |
// |           enable      - 1 = scan, 0 = display dark                         |
// |           digits_bcd  - packed BCD digits, digit i at [4i+3:4i]            |
// |           seg7        - registered segment pattern                         |
// |           dig_sel     - registered active-low digit enables                |
// |           frame_tick  - one-cycle pulse at end of each frame               |
// |           master: source of enable/digits, sink of display pins            |
// |           slave : the scan controller itself                               |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface seg7_scan_ctrl_if
   import seg7_pkg::*;
#(
   parameter int N_DIGITS = 2
) ();

   logic                          enable;
   logic [DIGIT_W*N_DIGITS-1:0]   digits_bcd;
   logic [SEG_W-1:0]              seg7;
   logic [N_DIGITS-1:0]           dig_sel;
   logic                          frame_tick;

   modport master (
      output enable,
      output digits_bcd,
      input  seg7,
      input  dig_sel,
      input  frame_tick
   );

   modport slave (
      input  enable,
      input  digits_bcd,
      output seg7,
      output dig_sel,
      output frame_tick
   );

endinterface
`default_nettype wire

// File: rtl/seg7_scan_ctrl_segment7.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : segment7                                                         |
// | Purpose : Combinational hex to 7-segment decoder, active-high segments.    |
// |           num  - 4-bit value 0..15                                         |
// |           seg7 - {g,f,e,d,c,b,a}; 10..15 render as A b C d E F            |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module segment7
   import seg7_pkg::*;
(
   input  logic [DIGIT_W-1:0] num,
   output logic [SEG_W-1:0]   seg7
);

   always_comb begin
      seg7 = 7'h00;
      case (num)
         4'h0: seg7 = 7'h3F;
         4'h1: seg7 = 7'h06;
         4'h2: seg7 = 7'h5B;
         4'h3: seg7 = 7'h4F;
         4'h4: seg7 = 7'h66;
         4'h5: seg7 = 7'h6D;
         4'h6: seg7 = 7'h7D;
         4'h7: seg7 = 7'h07;
         4'h8: seg7 = 7'h7F;
         4'h9: seg7 = 7'h6F;
         4'hA: seg7 = 7'h77;
         4'hB: seg7 = 7'h7C;
         4'hC: seg7 = 7'h39;
         4'hD: seg7 = 7'h5E;
         4'hE: seg7 = 7'h79;
         4'hF: seg7 = 7'h71;
         default: seg7 = 7'h00;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seg7_scan_ctrl                                                   |
// | Purpose : Time-multiplexed scan controller for an N-digit common-pin       |
// |           7-segment display. One shared segment7 decoder is handed to one  |
// |           digit per refresh slot; each slot starts with a dark gap; the    |
// |           input digits are snapshotted once per frame.                     |
// | Ports   : clk  - system clock, rising edge                                 |
// |           rst  - synchronous reset, active-high, priority over enable      |
// |           bus  - seg7_scan_ctrl_if.slave (enable, digits_bcd, seg7,        |
// |                  dig_sel, frame_tick)                                      |
// | Params  : N_DIGITS 1..8, REFRESH_DIV >= 2 cycles per slot,                 |
// |           BLANK_CYCLES < REFRESH_DIV dark cycles at start of each slot     |
// | Config  : LEADING_ZERO_BLANK_EN - when defined, upper digits that are 0    |
// |           together with every digit above them stay dark (digit 0 never).  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int N_DIGITS     = 2,
   parameter int REFRESH_DIV  = 1000,
   parameter int BLANK_CYCLES = 50
) (
   input  logic             clk,
   input  logic             rst,
   seg7_scan_ctrl_if.slave  bus
);

   localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int SLOT_W = $clog2(REFRESH_DIV);

   localparam logic [SLOT_W-1:0]   c_slot_last = SLOT_W'(REFRESH_DIV - 1);
   localparam logic [SLOT_W-1:0]   c_blank_end = SLOT_W'(BLANK_CYCLES);
   localparam logic [IDX_W-1:0]    c_idx_last  = IDX_W'(N_DIGITS - 1);
   localparam logic [N_DIGITS-1:0] c_dig_off   = DIG_ALL_OFF[N_DIGITS-1:0];

   logic [SLOT_W-1:0]                      r_slot_cnt;
   logic [IDX_W-1:0]                       r_idx;
   logic [N_DIGITS-1:0][DIGIT_W-1:0]       r_snap;

   logic [0:0]          w_phase;
   logic [DIGIT_W-1:0]  w_cur_digit;
   logic [SEG_W-1:0]    w_seg;
   logic [N_DIGITS-1:0] w_sel_show;
   logic [N_DIGITS-1:0] w_lz_dark;
   logic                w_slot_wrap;
   logic                w_frame_end;

   // ---------------------------------------------------------------------
   // Slot phase and wrap decode
   // ---------------------------------------------------------------------
   always_comb begin
      w_phase     = (r_slot_cnt < c_blank_end) ? SCAN_BLANK : SCAN_SHOW;
      w_slot_wrap = (r_slot_cnt == c_slot_last);
      w_frame_end = w_slot_wrap && (r_idx == c_idx_last);
   end

   // ---------------------------------------------------------------------
   // Shared decoder, fed from the snapshot of the digit being scanned
   // ---------------------------------------------------------------------
   always_comb begin
      w_cur_digit = r_snap[r_idx];
   end

   segment7 u_segment7 (
      .num  (w_cur_digit),
      .seg7 (w_seg)
   );

   // ---------------------------------------------------------------------
   // Leading-zero suppression mask (1 = keep that digit dark)
   // ---------------------------------------------------------------------
`ifdef LEADING_ZERO_BLANK_EN
   always_comb begin : lz_mask
      logic zero_run;
      zero_run  = 1'b1;
      w_lz_dark = '0;
      // Walk from the most significant digit down; a digit is dark only while
      // every digit from the top down to it is zero. Digit 0 is exempt so a
      // value of all zeros still shows a single "0".
      for (int i = N_DIGITS - 1; i > 0; i--) begin
         zero_run     = zero_run & (r_snap[i] == '0);
         w_lz_dark[i] = zero_run;
      end
   end
`else
   always_comb begin
      w_lz_dark = '0;
   end
`endif

   // ---------------------------------------------------------------------
   // Active-low enable for the digit owning the current slot
   // ---------------------------------------------------------------------
   always_comb begin
      w_sel_show = c_dig_off;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (r_idx == IDX_W'(i)) begin
            w_sel_show[i] = 1'b0;
         end
      end
      w_sel_show = w_sel_show | w_lz_dark;
   end

   // ---------------------------------------------------------------------
   // Scan state and registered outputs. Outputs reflect the state before
   // the edge, so the pins lag the counters by one cycle.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_slot_cnt     <= '0;
         r_idx          <= '0;
         r_snap         <= '0;
         bus.seg7       <= '0;
         bus.dig_sel    <= c_dig_off;
         bus.frame_tick <= 1'b0;
      end else if (!bus.enable) begin
         // Held at the start of a frame; the snapshot tracks the input so
         // the first frame after enable shows current data.
         r_slot_cnt     <= '0;
         r_idx          <= '0;
         r_snap         <= bus.digits_bcd;
         bus.seg7       <= w_seg;
         bus.dig_sel    <= c_dig_off;
         bus.frame_tick <= 1'b0;
      end else begin
         bus.seg7       <= w_seg;
         bus.dig_sel    <= (w_phase == SCAN_SHOW) ? w_sel_show : c_dig_off;
         bus.frame_tick <= w_frame_end;

         if (w_slot_wrap) begin
            r_slot_cnt <= '0;
            r_idx      <= (r_idx == c_idx_last) ? '0 : r_idx + 1'b1;
         end else begin
            r_slot_cnt <= r_slot_cnt + 1'b1;
         end

         // New data is taken only at the frame boundary so a frame never
         // mixes old and new digits.
         if (w_frame_end) begin
            r_snap <= bus.digits_bcd;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_seg7_scan_ctrl                                                |
// | Purpose : Self-checking bench for seg7_scan_ctrl (N=2, DIV=8, BLANK=2).    |
// |           A cycle-level reference model derived from frame arithmetic      |
// |           predicts seg7/dig_sel/frame_tick every cycle; directed checks    |
// |           cover the reset latency, frame period, enable drop, leading      |
// |           zero handling and hex codes. Honours LEADING_ZERO_BLANK_EN.      |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_seg7_scan_ctrl;

   localparam int N = 2;
   localparam int R = 8;
   localparam int B = 2;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   seg7_scan_ctrl_if #(.N_DIGITS(N)) bus ();

   seg7_scan_ctrl #(
      .N_DIGITS     (N),
      .REFRESH_DIV  (R),
      .BLANK_CYCLES (B)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: position within the current run of enabled cycles,
   // plus the digits latched for the frame being displayed.
   int         m_pos;
   logic [7:0] m_snap;
   logic [6:0] e_seg;
   logic [1:0] e_dig;
   logic       e_tick;

   function automatic logic [6:0] ref_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
         4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
         4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
         4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
      endcase
      return s;
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Predict the post-edge outputs from the pre-edge model state and inputs,
   // advance one clock, then compare.
   task automatic step();
      int   slot;
      int   d;
      logic lit;
      d = (m_pos / R) % N;
      if (rst) begin
         e_seg  = 7'h00;
         e_dig  = 2'b11;
         e_tick = 1'b0;
         m_snap = 8'h00;
         m_pos  = 0;
      end else if (!bus.enable) begin
         e_seg  = ref_seg(m_snap[4*d +: 4]);
         e_dig  = 2'b11;
         e_tick = 1'b0;
         m_snap = bus.digits_bcd;
         m_pos  = 0;
      end else begin
         slot  = m_pos % R;
         e_seg = ref_seg(m_snap[4*d +: 4]);
         lit   = (slot >= B);
`ifdef LEADING_ZERO_BLANK_EN
         if (d > 0 && (m_snap >> (4*d)) == 8'h00) lit = 1'b0;
`endif
         e_dig = 2'b11;
         if (lit) e_dig[d] = 1'b0;
         m_pos++;
         if (m_pos % (N*R) == 0) begin
            e_tick = 1'b1;
            m_snap = bus.digits_bcd;
         end else begin
            e_tick = 1'b0;
         end
      end
      @(posedge clk);
      #1;
      chk("seg7", bus.seg7, e_seg);
      chk("dig_sel", bus.dig_sel, e_dig);
      chk("frame_tick", bus.frame_tick, e_tick);
   endtask

   // Step until frame_tick is seen; n = cycles taken
   task automatic wait_tick(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.frame_tick && n < 100);
      if (n >= 100) chk("tick_timeout", 0, 1);
   endtask

   // Step until the model is in the SHOW phase of digit 1, a few cycles in
   task automatic wait_d1_show();
      int k;
      k = 0;
      while (!(((m_pos / R) % N) == 1 && (m_pos % R) >= B + 2) && k < 100) begin
         step();
         k++;
      end
      if (k >= 100) chk("d1_show_timeout", 0, 1);
   endtask

   initial begin
      int n;
      int k;
      int cnt;

      m_pos  = 0;
      m_snap = 8'h00;
      rst    = 1'b1;
      bus.enable     = 1'b1;
      bus.digits_bcd = 8'h19;

      // Reset held for three cycles
      repeat (3) step();

      // Release: first lit digit appears three cycles later
      rst = 1'b0;
      k   = 0;
      do begin
         step();
         k++;
      end while (bus.dig_sel != 2'b10 && k < 20);
      chk("first_lit_delay", k, 3);

      // Steady 19: frame period
      wait_tick(n);
      wait_tick(n);
      chk("frame_period", n, 16);
      repeat (20) step();

      // Change input during the digit-0 slot; must hold until next frame
      wait_tick(n);
      repeat (3) step();
      bus.digits_bcd = 8'h07;
      wait_tick(n);
      repeat (18) step();

      // Enable drop during digit-1 SHOW, then re-enable with new data
      wait_d1_show();
      bus.enable = 1'b0;
      step();
      chk("disable_dark", bus.dig_sel, 2'b11);
      chk("disable_no_tick", bus.frame_tick, 1'b0);
      repeat (2) step();
      bus.digits_bcd = 8'h42;
      bus.enable     = 1'b1;
      repeat (20) step();

      // Leading zero: digit 1 of 05
      bus.digits_bcd = 8'h05;
      wait_tick(n);
      cnt = 0;
      for (int i = 0; i < 32; i++) begin
         step();
         if (bus.dig_sel == 2'b01) cnt++;
      end
`ifdef LEADING_ZERO_BLANK_EN
      chk("lzb_d1_dark", cnt, 0);
`else
      chk("d1_lit_cycles", cnt, 12);
`endif

      // All zeros: digit 0 always lit
      bus.digits_bcd = 8'h00;
      wait_tick(n);
      cnt = 0;
      for (int i = 0; i < 32; i++) begin
         step();
         if (bus.dig_sel == 2'b10) cnt++;
      end
      chk("d0_lit_zero", cnt, 12);

      // Reset pulse during digit-1 SHOW, then hex code 10
      bus.digits_bcd = 8'h19;
      wait_d1_show();
      rst = 1'b1;
      step();
      chk("rst_dig_sel", bus.dig_sel, 2'b11);
      chk("rst_seg7", bus.seg7, 7'h00);
      rst = 1'b0;
      bus.digits_bcd = 8'h0A;
      wait_tick(n);
      k = 0;
      do begin
         step();
         k++;
      end while (bus.dig_sel != 2'b10 && k < 40);
      chk("hex_a_seg7", bus.seg7, 7'h77);

      // Randomised run
      for (int i = 0; i < 800; i++) begin
         rst        = ($urandom_range(0, 149) == 0);
         bus.enable = ($urandom_range(0, 29) != 0);
         if ($urandom_range(0, 9) == 0) bus.digits_bcd = 8'($urandom);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
